// File: rtl/myo_frame_decoder.sv
// Assembles spi_master receive words into one myo motor status frame and commits the fields atomically.
// Build option: define MYO_CHECKSUM_EN for 8-word frames whose last word is the XOR of words 0..6.
module myo_frame_decoder #(
    parameter logic [15:0] HEADER_WORD    = 16'h8000,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        data_read_valid,
    input  logic [15:0] data_read,
    output logic [31:0] position,
    output logic [31:0] velocity,
    output logic [15:0] current,
    output logic [15:0] displacement,
    output logic        frame_valid,
    output logic [15:0] frame_count,
    output logic [7:0]  error_count,
    output logic        busy
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

`ifdef MYO_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd7;
`else
    localparam logic [2:0] LAST_IDX = 3'd6;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         idx;
    logic [TIMER_W-1:0] timer;

    logic [15:0] sh_pos_hi;
    logic [15:0] sh_pos_lo;
    logic [15:0] sh_vel_hi;
    logic [15:0] sh_vel_lo;
    logic [15:0] sh_current;
    logic [15:0] sh_disp;

    logic       frame_good;
    logic [7:0] error_next;
    logic       timed_out;

`ifdef MYO_CHECKSUM_EN
    logic [15:0] xor_acc;
    logic        cs_ok;
    assign frame_good = cs_ok;
`else
    assign frame_good = 1'b1;
`endif

    // error counter saturates instead of wrapping
    assign error_next = (error_count == 8'hFF) ? 8'hFF : error_count + 8'd1;
    assign timed_out  = !data_read_valid && (timer == TIMER_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= 3'd0;
            timer        <= '0;
            sh_pos_hi    <= 16'd0;
            sh_pos_lo    <= 16'd0;
            sh_vel_hi    <= 16'd0;
            sh_vel_lo    <= 16'd0;
            sh_current   <= 16'd0;
            sh_disp      <= 16'd0;
            position     <= 32'd0;
            velocity     <= 32'd0;
            current      <= 16'd0;
            displacement <= 16'd0;
            frame_valid  <= 1'b0;
            frame_count  <= 16'd0;
            error_count  <= 8'd0;
            busy         <= 1'b0;
`ifdef MYO_CHECKSUM_EN
            xor_acc      <= 16'd0;
            cs_ok        <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // hunt for sync; non-header words are dropped silently
                    if (!frame_start && data_read_valid && (data_read == HEADER_WORD)) begin
                        state <= COLLECT;
                        busy  <= 1'b1;
                        idx   <= 3'd1;
                        timer <= '0;
`ifdef MYO_CHECKSUM_EN
                        xor_acc <= data_read;
                        cs_ok   <= 1'b0;
`endif
                    end
                end

                COLLECT: begin
                    // abort by resync or inactivity costs exactly one error
                    if (frame_start || timed_out) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        idx         <= 3'd0;
                        timer       <= '0;
                        error_count <= error_next;
                    end else if (data_read_valid) begin
                        case (idx)
                            3'd1:    sh_pos_hi  <= data_read;
                            3'd2:    sh_pos_lo  <= data_read;
                            3'd3:    sh_vel_hi  <= data_read;
                            3'd4:    sh_vel_lo  <= data_read;
                            3'd5:    sh_current <= data_read;
                            3'd6:    sh_disp    <= data_read;
                            default: ;
                        endcase
`ifdef MYO_CHECKSUM_EN
                        if (idx == 3'd7) begin
                            cs_ok <= (data_read == xor_acc);
                        end else begin
                            xor_acc <= xor_acc ^ data_read;
                        end
`endif
                        timer <= '0;
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                            idx   <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                CHECK: begin
                    // words arriving now are dropped; all fields commit on one edge
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!frame_start && frame_good) begin
                        position     <= {sh_pos_hi, sh_pos_lo};
                        velocity     <= {sh_vel_hi, sh_vel_lo};
                        current      <= sh_current;
                        displacement <= sh_disp;
                        frame_valid  <= 1'b1;
                        frame_count  <= frame_count + 16'd1;
                    end else begin
                        error_count <= error_next;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    idx   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_myo_frame_decoder.sv
// Directed self-checking bench for myo_frame_decoder; follows MYO_CHECKSUM_EN for frame length.
module tb_myo_frame_decoder;

`ifdef MYO_CHECKSUM_EN
    localparam int NW = 8;
    localparam logic [7:0] ERR0 = 8'd1;
`else
    localparam int NW = 7;
    localparam logic [7:0] ERR0 = 8'd0;
`endif

    localparam logic [15:0] FRM_A [8] = '{16'h8000, 16'h0001, 16'h2345, 16'hFFFF,
                                          16'hFFF6, 16'h0123, 16'h0456, 16'hA638};
    localparam logic [15:0] FRM_B [8] = '{16'h8000, 16'h1111, 16'h2222, 16'h3333,
                                          16'h4444, 16'h5555, 16'h6666, 16'hF777};
    localparam logic [15:0] FRM_X [8] = '{16'h8000, 16'h0001, 16'h2345, 16'hFFFF,
                                          16'hFFF6, 16'h0123, 16'h0456, 16'hA639};

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        data_read_valid = 1'b0;
    logic [15:0] data_read = 16'd0;
    logic [31:0] position;
    logic [31:0] velocity;
    logic [15:0] current;
    logic [15:0] displacement;
    logic        frame_valid;
    logic [15:0] frame_count;
    logic [7:0]  error_count;
    logic        busy;

    int total = 0;
    int bad = 0;
    int fv_pulses = 0;
    int fv_mark;

    myo_frame_decoder #(.HEADER_WORD(16'h8000), .TIMEOUT_CYCLES(50)) dut (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
        .data_read_valid(data_read_valid), .data_read(data_read),
        .position(position), .velocity(velocity), .current(current),
        .displacement(displacement), .frame_valid(frame_valid),
        .frame_count(frame_count), .error_count(error_count), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (frame_valid) fv_pulses++;

    task automatic send_word(input logic [15:0] w, input int gap);
        @(negedge clock);
        data_read_valid = 1'b1;
        data_read = w;
        @(negedge clock);
        data_read_valid = 1'b0;
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic send_range(input logic [15:0] f [8], input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) send_word(f[i], gap);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        data_read_valid = 1'b1;
        data_read = 16'h8000;
        repeat (3) @(negedge clock);
        total++; if (position !== 32'd0) begin bad++; $display("FAIL reset_position got=%h want=0", position); end
        total++; if (velocity !== 32'd0) begin bad++; $display("FAIL reset_velocity got=%h want=0", velocity); end
        total++; if (current !== 16'd0 || displacement !== 16'd0) begin bad++; $display("FAIL reset_cur_disp got=%h/%h want=0/0", current, displacement); end
        total++; if (frame_count !== 16'd0 || error_count !== 8'd0) begin bad++; $display("FAIL reset_counts got=%h/%h want=0/0", frame_count, error_count); end
        total++; if (busy !== 1'b0 || frame_valid !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b/%b want=0/0", busy, frame_valid); end
        data_read_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_good_frame();
        send_range(FRM_A, 0, NW - 2, 19);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL good_busy got=%b want=1", busy); end
        @(negedge clock);
        data_read_valid = 1'b1;
        data_read = FRM_A[NW-1];
        @(negedge clock);
        data_read_valid = 1'b0;
        total++; if (frame_valid !== 1'b0 || position !== 32'd0) begin bad++; $display("FAIL good_edge1 got fv=%b pos=%h want fv=0 pos=0", frame_valid, position); end
        @(negedge clock);
        total++; if (frame_valid !== 1'b1 || position !== 32'h00012345) begin bad++; $display("FAIL good_edge2 got fv=%b pos=%h want fv=1 pos=00012345", frame_valid, position); end
        @(negedge clock);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL good_pulse_width got=%b want=0", frame_valid); end
        total++; if (velocity !== 32'hFFFFFFF6) begin bad++; $display("FAIL good_velocity got=%h want=FFFFFFF6", velocity); end
        total++; if (current !== 16'h0123 || displacement !== 16'h0456) begin bad++; $display("FAIL good_cur_disp got=%h/%h want=0123/0456", current, displacement); end
        total++; if (frame_count !== 16'd1 || error_count !== 8'd0) begin bad++; $display("FAIL good_counts got=%h/%h want=1/0", frame_count, error_count); end
        total++; if (fv_pulses !== 1) begin bad++; $display("FAIL good_pulses got=%0d want=1", fv_pulses); end
    endtask

    task automatic test_bad_checksum();
`ifdef MYO_CHECKSUM_EN
        fv_mark = fv_pulses;
        send_range(FRM_X, 0, 7, 3);
        repeat (3) @(negedge clock);
        total++; if (position !== 32'h00012345 || velocity !== 32'hFFFFFFF6) begin bad++; $display("FAIL badcs_hold got=%h/%h want=00012345/FFFFFFF6", position, velocity); end
        total++; if (error_count !== 8'd1 || frame_count !== 16'd1) begin bad++; $display("FAIL badcs_counts got=%h/%h want=1/1", error_count, frame_count); end
        total++; if (fv_pulses !== fv_mark) begin bad++; $display("FAIL badcs_pulse got=%0d want=%0d", fv_pulses, fv_mark); end
`endif
    endtask

    task automatic test_sync_hunt();
        send_word(16'h1234, 2);
        send_word(16'h5678, 2);
        total++; if (busy !== 1'b0 || error_count !== ERR0) begin bad++; $display("FAIL hunt_junk got busy=%b err=%h want 0/%h", busy, error_count, ERR0); end
        send_range(FRM_B, 0, NW - 1, 2);
        repeat (2) @(negedge clock);
        total++; if (position !== 32'h11112222 || velocity !== 32'h33334444) begin bad++; $display("FAIL hunt_pos_vel got=%h/%h want=11112222/33334444", position, velocity); end
        total++; if (current !== 16'h5555 || displacement !== 16'h6666) begin bad++; $display("FAIL hunt_cur_disp got=%h/%h want=5555/6666", current, displacement); end
        total++; if (frame_count !== 16'd2 || error_count !== ERR0) begin bad++; $display("FAIL hunt_counts got=%h/%h want=2/%h", frame_count, error_count, ERR0); end
    endtask

    task automatic test_timeout_abort();
        send_range(FRM_A, 0, 3, 2);
        repeat (38) @(negedge clock);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_early got busy=%b want=1", busy); end
        repeat (20) @(negedge clock);
        total++; if (busy !== 1'b0 || error_count !== ERR0 + 8'd1) begin bad++; $display("FAIL timeout_abort got busy=%b err=%h want 0/%h", busy, error_count, ERR0 + 8'd1); end
        send_range(FRM_B, 0, 4, 2);
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        total++; if (busy !== 1'b0 || error_count !== ERR0 + 8'd2) begin bad++; $display("FAIL fs_abort got busy=%b err=%h want 0/%h", busy, error_count, ERR0 + 8'd2); end
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        @(negedge clock);
        total++; if (error_count !== ERR0 + 8'd2) begin bad++; $display("FAIL fs_idle got err=%h want=%h", error_count, ERR0 + 8'd2); end
        send_range(FRM_A, 0, NW - 1, 2);
        repeat (2) @(negedge clock);
        total++; if (position !== 32'h00012345 || frame_count !== 16'd3) begin bad++; $display("FAIL after_abort got pos=%h fc=%h want 00012345/3", position, frame_count); end
    endtask

    task automatic test_check_cycle();
        send_range(FRM_B, 0, NW - 2, 1);
        @(negedge clock);
        data_read_valid = 1'b1;
        data_read = FRM_B[NW-1];
        @(negedge clock);
        data_read = 16'h8000;
        @(negedge clock);
        data_read_valid = 1'b0;
        send_range(FRM_A, 1, NW - 1, 1);
        repeat (2) @(negedge clock);
        total++; if (position !== 32'h11112222 || frame_count !== 16'd4 || busy !== 1'b0) begin bad++; $display("FAIL check_drop got pos=%h fc=%h busy=%b want 11112222/4/0", position, frame_count, busy); end
        send_range(FRM_A, 0, NW - 2, 1);
        @(negedge clock);
        data_read_valid = 1'b1;
        data_read = FRM_A[NW-1];
        @(negedge clock);
        data_read_valid = 1'b0;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        @(negedge clock);
        total++; if (position !== 32'h11112222 || frame_count !== 16'd4) begin bad++; $display("FAIL fs_in_check got pos=%h fc=%h want 11112222/4", position, frame_count); end
        total++; if (error_count !== ERR0 + 8'd3) begin bad++; $display("FAIL fs_in_check_err got=%h want=%h", error_count, ERR0 + 8'd3); end
    endtask

    task automatic test_wrap_saturate();
        @(negedge clock);
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        send_range(FRM_A, 0, NW - 1, 1);
        repeat (2) @(negedge clock);
        total++; if (frame_count !== 16'd0 || position !== 32'h00012345) begin bad++; $display("FAIL wrap got fc=%h pos=%h want 0/00012345", frame_count, position); end
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            data_read_valid = 1'b1;
            data_read = 16'h8000;
            @(negedge clock);
            data_read_valid = 1'b0;
            frame_start = 1'b1;
            @(negedge clock);
            frame_start = 1'b0;
        end
        @(negedge clock);
        total++; if (error_count !== 8'hFF) begin bad++; $display("FAIL saturate got=%h want=FF", error_count); end
        total++; if (frame_count !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL saturate_side got fc=%h busy=%b want 0/0", frame_count, busy); end
    endtask

    task automatic test_midframe_reset();
        send_range(FRM_B, 0, 3, 1);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        total++; if (position !== 32'd0 || error_count !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset got pos=%h err=%h busy=%b want 0/0/0", position, error_count, busy); end
        send_range(FRM_B, 4, NW - 1, 1);
        total++; if (frame_count !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset_tail got fc=%h busy=%b want 0/0", frame_count, busy); end
        send_range(FRM_A, 0, NW - 1, 1);
        repeat (2) @(negedge clock);
        total++; if (position !== 32'h00012345 || frame_count !== 16'd1) begin bad++; $display("FAIL mid_reset_recover got pos=%h fc=%h want 00012345/1", position, frame_count); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_sync_hunt();
        test_timeout_abort();
        test_check_cycle();
        test_wrap_saturate();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
